// File: rtl/kmer_hash_engine.sv
// -----------------------------------------------------------------------------
// kmer_hash_engine
//
// Lane-parallel, multi-cycle hash engine for the k-mer stage of the de novo
// pipeline. A transaction carries NUM_KMERS packed k-mers plus two random
// coefficients. The engine computes, for every k-mer i:
//    h[i] = ((rand_a & kmer[i]) | rand_b) % MOD_N
// LANES k-mers are hashed per cycle, so a transaction takes BEATS cycles. The
// full result vector is then presented with a valid/ready handshake.
//
// Optional feature (compile-time macro MIN_TRACK_EN):
//    adds min_hash/min_idx outputs holding the smallest h[i] and its index.
//    Ties keep the lowest index. Without the macro the ports and the compare
//    logic do not exist.
//
// Ports
//    clk           in   clock
//    rstN          in   reset, asynchronous, ACTIVE-HIGH (historic name)
//    in_valid      in   input transaction valid
//    in_ready      out  engine idle and able to accept a transaction
//    rand_a        in   AND coefficient, latched at accept
//    rand_b        in   OR coefficient, latched at accept
//    kmers         in   packed k-mers, k-mer i at [i*KMER_W +: KMER_W]
//    out_valid     out  result vector valid (held until out_ready)
//    out_ready     in   downstream accepts the result
//    hash_results  out  packed results, h[i] at [i*HASH_W +: HASH_W]
//    busy          out  engine is computing or holding a result
//    min_hash      out  (MIN_TRACK_EN) smallest h[i]
//    min_idx       out  (MIN_TRACK_EN) index of min_hash
// -----------------------------------------------------------------------------
module kmer_hash_engine #(
   parameter  int KMER_W    = 32,
   parameter  int NUM_KMERS = 49,
   parameter  int LANES     = 7,
   parameter  int MOD_N     = 255,
   localparam int HASH_W    = $clog2(MOD_N),
   localparam int IDX_W     = (NUM_KMERS > 1) ? $clog2(NUM_KMERS) : 1
) (
   input  logic                        clk,
   input  logic                        rstN,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [KMER_W-1:0]           rand_a,
   input  logic [KMER_W-1:0]           rand_b,
   input  logic [NUM_KMERS*KMER_W-1:0] kmers,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_KMERS*HASH_W-1:0] hash_results,
   output logic                        busy
`ifdef MIN_TRACK_EN
   ,
   output logic [HASH_W-1:0]           min_hash,
   output logic [IDX_W-1:0]            min_idx
`endif
);

   localparam int BEATS  = (NUM_KMERS + LANES - 1) / LANES;
   localparam int BEAT_W = $clog2(BEATS + 1);
   localparam logic [KMER_W-1:0]  MOD_K     = KMER_W'(MOD_N);
   localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [BEAT_W-1:0]           beat_q;
   logic [KMER_W-1:0]           a_q;
   logic [KMER_W-1:0]           b_q;
   logic [NUM_KMERS*KMER_W-1:0] kmers_q;

   logic accept;
   logic last_beat;

   logic [HASH_W-1:0] lane_hash [LANES];
   logic [LANES-1:0]  lane_en;

   // Global k-mer index handled by lane l during beat b.
   function automatic int lane_index(input logic [BEAT_W-1:0] b, input int l);
      return int'(b) * LANES + l;
   endfunction

   function automatic logic [HASH_W-1:0] hash_one(input logic [KMER_W-1:0] a,
                                                  input logic [KMER_W-1:0] b,
                                                  input logic [KMER_W-1:0] k);
      logic [KMER_W-1:0] mixed;
      mixed = (a & k) | b;
      // The remainder is < MOD_N <= 2**HASH_W, so truncation loses nothing.
      return HASH_W'(mixed % MOD_K);
   endfunction

   // --------------------------------------------------------------------------
   // Control FSM
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rstN) begin
      if (rstN) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign last_beat = (beat_q == LAST_BEAT);

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = S_CALC;
         end
         S_CALC: begin
            busy = 1'b1;
            if (last_beat) state_d = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

   // --------------------------------------------------------------------------
   // Lane hashing for the current beat; lanes past the last k-mer are idle.
   // --------------------------------------------------------------------------
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_en[l]   = (lane_index(beat_q, l) < NUM_KMERS);
         lane_hash[l] = '0;
         if (lane_en[l]) begin
            lane_hash[l] = hash_one(a_q, b_q,
                                    kmers_q[lane_index(beat_q, l)*KMER_W +: KMER_W]);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Datapath: operand latches, beat counter, result vector
   // --------------------------------------------------------------------------
   // NOTE: the wide result vector is reset on purpose: an aborted transaction
   // must not leave partial hashes visible on hash_results.
   always_ff @(posedge clk or posedge rstN) begin
      if (rstN) begin
         beat_q       <= '0;
         a_q          <= '0;
         b_q          <= '0;
         kmers_q      <= '0;
         hash_results <= '0;
      end else if (accept) begin
         beat_q  <= '0;
         a_q     <= rand_a;
         b_q     <= rand_b;
         kmers_q <= kmers;
      end else if (state_q == S_CALC) begin
         beat_q <= beat_q + BEAT_W'(1);
         for (int l = 0; l < LANES; l++) begin
            if (lane_en[l]) begin
               hash_results[lane_index(beat_q, l)*HASH_W +: HASH_W] <= lane_hash[l];
            end
         end
      end
   end

`ifdef MIN_TRACK_EN
   // --------------------------------------------------------------------------
   // Running minimum. Lanes are scanned in ascending index order with a strict
   // compare, so on a tie the earlier (lower) index survives.
   // --------------------------------------------------------------------------
   logic [HASH_W-1:0] min_d;
   logic [IDX_W-1:0]  idx_d;

   always_comb begin
      min_d = min_hash;
      idx_d = min_idx;
      for (int l = 0; l < LANES; l++) begin
         if (lane_en[l] && (lane_hash[l] < min_d)) begin
            min_d = lane_hash[l];
            idx_d = IDX_W'(lane_index(beat_q, l));
         end
      end
   end

   always_ff @(posedge clk or posedge rstN) begin
      if (rstN) begin
         min_hash <= '1;
         min_idx  <= '0;
      end else if (accept) begin
         min_hash <= '1;
         min_idx  <= '0;
      end else if (state_q == S_CALC) begin
         min_hash <= min_d;
         min_idx  <= idx_d;
      end
   end
`endif

endmodule
